// File: rtl/wdm_ring_lock_ctrl_pkg.sv
// wdm_pkg: shared FSM encoding, channel limit and sweep step helper for wdm_ring_lock_ctrl.
// No ports; imported by the controller, its peak tracker and the bench.
package wdm_pkg;
  localparam int WDM_MAX_CH = 16;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, COMMIT, DONE} lock_state_e;
  function automatic int wdm_sweep_steps(input int code_max, input int step);
    return code_max / step + 1;
  endfunction
endpackage

// File: rtl/wdm_ring_lock_ctrl_if.sv
// wdm_ring_lock_ctrl_if: command, photodetector and lock-result bundle of the lock controller.
// master: host/ADC side (drives start_i, abort_i, pd_pwr_i); slave: the controller (drives all *_o).
interface wdm_ring_lock_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CODE_W = 8,
  parameter int PWR_W  = 10
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic                     start_i;
  logic                     abort_i;
  logic [PWR_W-1:0]         pd_pwr_i;
  logic [CH_W-1:0]          tune_ch_o;
  logic [CODE_W-1:0]        tune_code_o;
  logic [NUM_CH*CODE_W-1:0] lock_code_o;
  logic [NUM_CH*PWR_W-1:0]  peak_pwr_o;
  logic [NUM_CH-1:0]        lock_valid_o;
  logic                     busy_o;
  logic                     done_o;
  modport master (output start_i, abort_i, pd_pwr_i,
                  input tune_ch_o, tune_code_o, lock_code_o, peak_pwr_o, lock_valid_o, busy_o, done_o);
  modport slave (input start_i, abort_i, pd_pwr_i,
                 output tune_ch_o, tune_code_o, lock_code_o, peak_pwr_o, lock_valid_o, busy_o, done_o);
endinterface

// File: rtl/wdm_ring_lock_ctrl_peak_tracker.sv
// wdm_peak_tracker: running peak power/code for the channel being swept.
// Ports: clk, rst; clr restarts the search; en marks a sample cycle, last the final sample of a step;
// code/pwr are the current step; best_code/best_pwr the peak so far (strict greater, ties keep lower code).
// WDM_LOCK_AVG_EN: sums the 4 samples of a step and reports the peak sum divided by 4.
module wdm_peak_tracker #(
  parameter int CODE_W = 8,
  parameter int PWR_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              last,
  input  logic [CODE_W-1:0] code,
  input  logic [PWR_W-1:0]  pwr,
  output logic [CODE_W-1:0] best_code,
  output logic [PWR_W-1:0]  best_pwr
);
`ifdef WDM_LOCK_AVG_EN
  localparam int SW = PWR_W + 2;
  logic [SW-1:0] acc, sum, best;
  assign sum = acc + SW'(pwr);
  assign best_pwr = best[SW-1:2];
  always_ff @(posedge clk)
    acc <= (rst || clr || (en && last)) ? '0 : en ? sum : acc;
`else
  localparam int SW = PWR_W;
  logic [SW-1:0] sum, best;
  assign sum = pwr;
  assign best_pwr = best;
`endif
  always_ff @(posedge clk)
    if (rst || clr) begin
      best      <= '0;
      best_code <= '0;
    end else if (en && last && sum > best) begin
      best      <= sum;
      best_code <= code;
    end
endmodule

// File: rtl/wdm_ring_lock_ctrl.sv
// wdm_ring_lock_ctrl: sequential per-channel ring sweep that locks each ring at its peak drop power.
// Ports: clk, rst (sync, active high); bus (slave): start_i/abort_i commands, pd_pwr_i ADC input,
// tune_ch_o/tune_code_o tuner drive, lock_code_o/peak_pwr_o/lock_valid_o results, busy_o, done_o.
// WDM_LOCK_AVG_EN: each sample step lasts 4 cycles and compares the averaged power.
module wdm_ring_lock_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int CODE_W        = 8,
  parameter int PWR_W         = 10,
  parameter int CODE_MAX      = 255,
  parameter int STEP          = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  wdm_ring_lock_ctrl_if.slave bus
);
  import wdm_pkg::*;
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
`ifdef WDM_LOCK_AVG_EN
  localparam int SAMP = 4;
`else
  localparam int SAMP = 1;
`endif
  localparam int CNT_W = $clog2((SETTLE_CYCLES > SAMP ? SETTLE_CYCLES : SAMP) + 1);
  lock_state_e              state, nxt;
  logic [CH_W-1:0]          ch;
  logic [CODE_W-1:0]        code, best_code;
  logic [PWR_W-1:0]         best_pwr;
  logic [CNT_W-1:0]         cnt;
  logic [CODE_W:0]          code_nx;
  logic                     go, commit;
  logic [NUM_CH*CODE_W-1:0] lock_code;
  logic [NUM_CH*PWR_W-1:0]  peak_pwr;
  logic [NUM_CH-1:0]        lock_valid;
  assign go      = state == IDLE && bus.start_i;
  assign commit  = state == COMMIT && !bus.abort_i;
  // one extra bit so a step past CODE_MAX is seen instead of wrapping to a low code
  assign code_nx = {1'b0, code} + (CODE_W+1)'(STEP);
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start_i ? SETTLE : IDLE;
      SETTLE:  nxt = cnt == '0 ? SAMPLE : SETTLE;
      SAMPLE:  nxt = cnt != '0 ? SAMPLE : code_nx <= (CODE_W+1)'(CODE_MAX) ? SETTLE : COMMIT;
      COMMIT:  nxt = ch == CH_W'(NUM_CH-1) ? DONE : SETTLE;
      default: nxt = IDLE;
    endcase
    if (bus.abort_i && state != IDLE) nxt = IDLE;
    bus.busy_o      = state != IDLE;
    bus.done_o      = state == DONE;
    bus.tune_ch_o   = (state == IDLE || state == DONE) ? '0 : ch;
    bus.tune_code_o = (state == IDLE || state == DONE) ? '0 : code;
  end
  // cnt reloads on entry to SETTLE / SAMPLE and counts down to 0, the last cycle of each
  always_ff @(posedge clk)
    if (rst) begin
      cnt  <= '0;
      ch   <= '0;
      code <= '0;
    end else begin
      cnt  <= (nxt == SETTLE && state != SETTLE) ? CNT_W'(SETTLE_CYCLES-1) :
              (nxt == SAMPLE && state != SAMPLE) ? CNT_W'(SAMP-1) : cnt - 1'b1;
      ch   <= go ? '0 : (state == COMMIT && nxt == SETTLE) ? ch + 1'b1 : ch;
      code <= (go || state == COMMIT) ? '0 : (state == SAMPLE && nxt == SETTLE) ? code_nx[CODE_W-1:0] : code;
    end
  always_ff @(posedge clk)
    if (rst) begin
      lock_code  <= '0;
      peak_pwr   <= '0;
      lock_valid <= '0;
    end else if (go) begin
      lock_valid <= '0;
    end else if (commit) begin
      lock_code[ch*CODE_W +: CODE_W] <= best_code;
      peak_pwr[ch*PWR_W +: PWR_W]    <= best_pwr;
      lock_valid[ch]                 <= 1'b1;
    end
  assign bus.lock_code_o  = lock_code;
  assign bus.peak_pwr_o   = peak_pwr;
  assign bus.lock_valid_o = lock_valid;
  wdm_peak_tracker #(.CODE_W(CODE_W), .PWR_W(PWR_W)) u_peak (
    .clk(clk), .rst(rst), .clr(go || state == COMMIT), .en(state == SAMPLE), .last(cnt == '0),
    .code(code), .pwr(bus.pd_pwr_i), .best_code(best_code), .best_pwr(best_pwr)
  );
endmodule

// File: tb/tb_wdm_ring_lock_ctrl.sv
// tb_wdm_ring_lock_ctrl: randomized power maps checked every cycle against a sweep-timeline model.
`timescale 1ns/1ps
module tb_wdm_ring_lock_ctrl;
  import wdm_pkg::*;
  localparam int N = 4, CW = 8, PW = 10, CMAX = 255, STEP = 16, SET = 4;
`ifdef WDM_LOCK_AVG_EN
  localparam int SAMP = 4;
`else
  localparam int SAMP = 1;
`endif
  localparam int S    = CMAX / STEP + 1;
  localparam int L    = S * (SET + SAMP) + 1;
  localparam int PK   = SAMP == 4 ? 500 : 900;
  localparam int S2   = 250 / 16 + 1;
  localparam int SET2 = 2;
  logic clk = 0, rst = 1, tog = 0;
  int n_chk = 0, n_fail = 0, done_cnt = 0;
  bit chk_en = 0;
  logic [PW-1:0] tbl [N][S];
  logic [PW-1:0] tbl2 [S2];
  bit m_act = 0;
  int m_t = 0;
  logic [CW-1:0] m_lock [N];
  logic [PW-1:0] m_peak [N];
  logic [N-1:0]  m_val = '0;
  wdm_ring_lock_ctrl_if #(.NUM_CH(N), .CODE_W(CW), .PWR_W(PW)) bus();
  wdm_ring_lock_ctrl_if #(.NUM_CH(1), .CODE_W(CW), .PWR_W(PW)) bus2();
  wdm_ring_lock_ctrl #(.NUM_CH(N), .CODE_W(CW), .PWR_W(PW), .CODE_MAX(CMAX), .STEP(STEP),
                       .SETTLE_CYCLES(SET)) dut (.clk(clk), .rst(rst), .bus(bus));
  wdm_ring_lock_ctrl #(.NUM_CH(1), .CODE_W(CW), .PWR_W(PW), .CODE_MAX(250), .STEP(16),
                       .SETTLE_CYCLES(SET2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  // in averaging builds mid-range powers alternate +-100 so a 4-sample window averages to the table value
  function automatic logic [PW-1:0] dith(input logic [PW-1:0] v, input logic t);
    return (SAMP == 4 && v >= 100 && v <= 900) ? (t ? v + 10'd100 : v - 10'd100) : v;
  endfunction
  assign bus.pd_pwr_i  = dith(tbl[bus.tune_ch_o][bus.tune_code_o / STEP], tog);
  assign bus2.pd_pwr_i = dith(tbl2[bus2.tune_code_o / 16], tog);
  function automatic int max_pwr(input int c);
    int m = 0;
    for (int i = 0; i < S; i++) m = tbl[c][i] > m ? int'(tbl[c][i]) : m;
    return m;
  endfunction
  function automatic int lock_of(input int c);
    for (int i = 0; i < S; i++) if (int'(tbl[c][i]) == max_pwr(c)) return i * STEP;
    return 0;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // timeline model: t counts cycles since the start edge; channel c occupies [c*L, c*L+L-1], DONE at N*L
  always @(posedge clk) begin
    tog <= ~tog;
    if (rst) begin
      m_act <= 0;
      m_t   <= 0;
      m_val <= '0;
      for (int k = 0; k < N; k++) begin
        m_lock[k] <= '0;
        m_peak[k] <= '0;
      end
    end else if (!m_act) begin
      if (bus.start_i) begin
        m_act <= 1;
        m_t   <= 0;
        m_val <= '0;
      end
    end else if (bus.abort_i) begin
      m_act <= 0;
    end else begin
      if (m_t < N * L && m_t % L == L - 1) begin
        m_lock[m_t / L] <= CW'(lock_of(m_t / L));
        m_peak[m_t / L] <= PW'(max_pwr(m_t / L));
        m_val[m_t / L]  <= 1'b1;
      end
      if (m_t == N * L) m_act <= 0;
      else m_t <= m_t + 1;
    end
  end
  always @(negedge clk) begin
    bit run;
    int st;
    if (chk_en) begin
      run = m_act && m_t < N * L;
      st  = (m_t % L) / (SET + SAMP);
      chk("busy", bus.busy_o, m_act);
      chk("done", bus.done_o, m_act && m_t == N * L);
      chk("tune_ch", bus.tune_ch_o, run ? m_t / L : 0);
      chk("tune_code", bus.tune_code_o, run ? (st < S ? st : S - 1) * STEP : 0);
      chk("lock_valid", bus.lock_valid_o, m_val);
      for (int k = 0; k < N; k++) begin
        chk("lock_code", bus.lock_code_o[k*CW +: CW], m_lock[k]);
        chk("peak_pwr", bus.peak_pwr_o[k*PW +: PW], m_peak[k]);
      end
      if (bus.done_o) done_cnt++;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic run_seq(output int lat);
    bus.start_i = 1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start_i = 0;
    while (!bus.done_o && lat < 3000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("done_seen", bus.done_o, 1);
    cyc(1);
  endtask
  task automatic fill_rand();
    for (int c = 0; c < N; c++) for (int i = 0; i < S; i++) tbl[c][i] = PW'($urandom_range(100, 900));
  endtask
  initial begin
    int lat, d0, maxc, best;
    bus.start_i = 0; bus.abort_i = 0; bus2.start_i = 0; bus2.abort_i = 0;
    for (int c = 0; c < N; c++) for (int i = 0; i < S; i++) tbl[c][i] = '0;
    for (int i = 0; i < S2; i++) tbl2[i] = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    cyc(2);
    rst = 0;
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_valid", bus.lock_valid_o, 0);
    chk("reset_lock", bus.lock_code_o, 0);
    chk("reset_peak", bus.peak_pwr_o, 0);
    chk("sweep_steps", wdm_sweep_steps(CMAX, STEP), 16);
    chk("sweep_steps_250", wdm_sweep_steps(250, 16), 16);
    // single peak at code 96 on every channel
    for (int c = 0; c < N; c++) for (int i = 0; i < S; i++) tbl[c][i] = i * STEP == 96 ? PW'(PK) : 10'd100;
    run_seq(lat);
    chk("latency", lat, SAMP == 4 ? 517 : 325);
    chk("peak96_lock", bus.lock_code_o, 32'h60606060);
    chk("peak96_pwr", bus.peak_pwr_o, {N{PW'(PK)}});
    chk("peak96_valid", bus.lock_valid_o, 4'hF);
    // equal peaks at 32 and 160: lower code wins
    for (int c = 0; c < N; c++) for (int i = 0; i < S; i++) tbl[c][i] = (i == 2 || i == 10) ? 10'd500 : 10'd100;
    run_seq(lat);
    chk("tie_lock", bus.lock_code_o, 32'h20202020);
    // all-zero channel still locks at 0 and is valid
    fill_rand();
    for (int i = 0; i < S; i++) tbl[1][i] = '0;
    run_seq(lat);
    chk("zero_lock", bus.lock_code_o[CW +: CW], 0);
    chk("zero_peak", bus.peak_pwr_o[PW +: PW], 0);
    chk("zero_valid", bus.lock_valid_o, 4'hF);
    // abort on entry to channel 2
    fill_rand();
    bus.start_i = 1;
    cyc(1);
    bus.start_i = 0;
    for (int k = 0; k < 3 * L && bus.tune_ch_o != 2; k++) cyc(1);
    chk("reach_ch2", bus.tune_ch_o, 2);
    d0 = done_cnt;
    bus.abort_i = 1;
    cyc(1);
    bus.abort_i = 0;
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_valid", bus.lock_valid_o, 4'b0011);
    cyc(L);
    chk("abort_no_done", done_cnt, d0);
    // start while busy is ignored
    fill_rand();
    bus.start_i = 1;
    cyc(1);
    bus.start_i = 0;
    cyc(50);
    bus.start_i = 1;
    cyc(1);
    bus.start_i = 0;
    for (int k = 0; k < 3000 && !bus.done_o; k++) cyc(1);
    chk("busy_start_done", bus.done_o, 1);
    cyc(1);
    // reset mid-sweep
    bus.start_i = 1;
    cyc(1);
    bus.start_i = 0;
    cyc(100);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_valid", bus.lock_valid_o, 0);
    chk("midrst_lock", bus.lock_code_o, 0);
    chk("midrst_peak", bus.peak_pwr_o, 0);
    chk("midrst_code", bus.tune_code_o, 0);
    // random maps, a random abort, then a full run
    repeat (3) begin
      fill_rand();
      run_seq(lat);
    end
    fill_rand();
    bus.start_i = 1;
    cyc(1);
    bus.start_i = 0;
    cyc($urandom_range(1, N * L - 1));
    bus.abort_i = 1;
    cyc(1);
    bus.abort_i = 0;
    fill_rand();
    run_seq(lat);
    // single-channel instance: CODE_MAX=250 must stop at 240
    for (int i = 0; i < S2; i++) tbl2[i] = PW'($urandom_range(100, 900));
    best = 0;
    for (int i = 1; i < S2; i++) best = tbl2[i] > tbl2[best] ? i : best;
    bus2.start_i = 1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus2.start_i = 0;
    maxc = 0;
    while (!bus2.done_o && lat < 1000) begin
      maxc = (bus2.busy_o && int'(bus2.tune_code_o) > maxc) ? int'(bus2.tune_code_o) : maxc;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("ch1_latency", lat, SAMP == 4 ? 98 : 50);
    chk("ch1_max_code", maxc, 240);
    chk("ch1_lock", bus2.lock_code_o, best * 16);
    chk("ch1_peak", bus2.peak_pwr_o, tbl2[best]);
    chk("ch1_valid", bus2.lock_valid_o, 1);
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wdm_ring_lock_ctrl.md
Name: wdm_ring_lock_ctrl

Overview:
- Multi-channel wavelength-lock controller for ring-resonator WDM links.
- Works through channels one at a time. For each channel it sweeps a tuning code, samples the digitised drop-port photodetector power at every step, and latches the code that gave peak power as that channel's lock code.
- Generalises the single-bundle wave typing to NUM_CH channels with run-time sequencing. Sits between the ring tuner DACs and the per-channel photodetector ADC mux.

Parameters:
- NUM_CH, 4, number of WDM channels/rings; legal values 1, 4, 8, 16.
- CODE_W, 8, tuning DAC code width.
- PWR_W, 10, photodetector ADC code width.
- CODE_MAX, 255, last legal tuning code; must be ≤ 2**CODE_W-1.
- STEP, 16, sweep increment; must be ≥ 1.
- SETTLE_CYCLES, 4, thermal settle wait before each sample; must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  begin full lock sequence; ignored unless IDLE
- abort_i  in  1  cancel sequence; return to IDLE
- pd_pwr_i  in  PWR_W  ADC power for the channel selected by tune_ch_o
- tune_ch_o  out  $clog2(NUM_CH) (min 1)  channel currently swept
- tune_code_o  out  CODE_W  code driven to the swept ring
- lock_code_o  out  NUM_CH*CODE_W  locked code per channel; ch k at [k*CODE_W +: CODE_W]
- peak_pwr_o  out  NUM_CH*PWR_W  power measured at each lock code
- lock_valid_o  out  NUM_CH  channel k lock_code/peak_pwr valid
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle pulse when the last channel commits

Behaviour:
- Reset: state=IDLE; all outputs 0, including lock_code_o, peak_pwr_o and lock_valid_o.
- States: IDLE, SETTLE, SAMPLE, COMMIT, DONE.
- IDLE + start_i:
  - Next cycle: SETTLE, ch=0, code=0, best_pwr=0, best_code=0, settle counter=SETTLE_CYCLES-1.
  - lock_valid_o cleared to 0 in that same cycle; lock_code_o and peak_pwr_o keep their old values until overwritten.
- SETTLE: counter decrements each cycle. At 0 go to SAMPLE. The state therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - If pd_pwr_i > best_pwr (strict), update best_pwr and best_code=code. Ties keep the lower code.
  - Then, if code+STEP ≤ CODE_MAX (evaluated in CODE_W+1 bits, no wrap), code += STEP and go to SETTLE. Otherwise go to COMMIT.
- COMMIT (1 cycle):
  - lock_code[ch]=best_code, peak_pwr[ch]=best_pwr, lock_valid[ch]=1.
  - If ch==NUM_CH-1, go to DONE. Otherwise ch++, code=0, best cleared, go to SETTLE.
- DONE: done_o=1 for this single cycle, then IDLE.
- Step count: S = CODE_MAX/STEP + 1 (integer division).
  - Per-channel cycles: S*(SETTLE_CYCLES+1) + 1.
  - Total from start_i sample to done_o: NUM_CH*(S*(SETTLE_CYCLES+1)+1) + 1.
- All-zero power on a channel: lock code 0, peak 0, valid still set.
- busy_o=1 in SETTLE, SAMPLE, COMMIT and DONE.
- tune_ch_o and tune_code_o are 0 in IDLE and DONE.
- start_i while busy is ignored.
- abort_i:
  - From any non-IDLE state, go to IDLE next cycle; no done_o.
  - Channels already committed keep their valid bit; the in-progress channel is discarded.
  - abort_i and start_i together in IDLE: start wins.
- rst mid-sequence: full reset values, identical to power-up.

Optional Feature:
- Macro WDM_LOCK_AVG_EN.
- Defined:
  - SAMPLE lasts 4 cycles and accumulates pd_pwr_i into a PWR_W+2-bit sum.
  - The comparison uses the sum; peak_pwr stores sum>>2.
  - Per-channel cycles become S*(SETTLE_CYCLES+4) + 1.
- Undefined: single-sample behaviour as above.

Decomposition:
- wdm_pkg gains:
  - lock_state_e enum (IDLE, SETTLE, SAMPLE, COMMIT, DONE);
  - WDM_MAX_CH=16 constant;
  - function wdm_sweep_steps(code_max, step) returning S, shared by RTL and bench.
- One sub-module, wdm_peak_tracker: holds best_pwr/best_code, with clear, sample-enable, strict-greater compare and optional averaging accumulator.

Test Plan:
- Defaults, pd_pwr_i=code==96 ? 900 : 100 → each channel locks 96/900; done_o exactly 4*(16*5+1)+1=325 cycles after start_i; lock_valid_o=4'hF.
- Equal peaks 500 at codes 32 and 160 → lock code 32 (tie keeps lower).
- CODE_MAX=250, STEP=16 → last tune_code_o=240, never 256/0 wrap; S=16.
- abort_i during channel 2 SETTLE → IDLE next cycle; lock_valid_o=4'b0011; no done_o.
- start_i pulsed while busy, and rst asserted mid-sweep → sequence unaffected by the start; after reset, all outputs 0 and busy_o=0.
- WDM_LOCK_AVG_EN with alternating 400/600 samples at peak code → peak_pwr=500; total latency 4*(16*8+1)+1=517 cycles.
